// File: rtl/burst_line_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : burst_line_ram
// Purpose  : Word-organised line-burst main memory. Serves whole cache-line
//            reads and writes as 32-bit beats with a configurable access
//            latency, critical-word-first wrap order and a write-beat
//            handshake. Big-endian within each word (DB/MD[31:24] is the
//            lowest byte address).
// Revision : 1.0 - initial release
// ============================================================================
module burst_line_ram #(
    parameter int ADDR_W     = 20,
    parameter int LINE_WORDS = 4,
    parameter int LAT        = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] AB,
    input  logic [31:0] DB,
    input  logic        db_valid,
    output logic        db_ready,
    output logic [31:0] MD,
    output logic        md_valid,
    output logic        md_last,
    output logic        busy,
    output logic        done
);

    localparam int                    c_widx_w    = ADDR_W - 2;
    localparam int                    c_words     = 2 ** c_widx_w;
    localparam logic [c_widx_w-1:0]   c_line_mask = c_widx_w'(LINE_WORDS - 1);
    localparam logic [4:0]            c_last_beat = 5'(LINE_WORDS - 1);

    // DONE is a one-cycle tail so busy stays up for the cycle done is shown
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_RBURST = 3'd2,
        S_WBURST = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic [4:0]            beat_q, beat_d;
    logic [c_widx_w-1:0]   widx_q, widx_d;
    logic                  we_q, we_d;
    logic [31:0]           md_q, md_d;
    logic                  md_valid_q, md_valid_d;
    logic                  md_last_q, md_last_d;
    logic                  db_ready_q, db_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [31:0]           mem [0:c_words-1];

    logic [c_widx_w-1:0]   w_idx;
    logic                  w_last;
    logic                  w_accept;
    logic [31:0]           w_rdata;

    // Upper address bits and byte-lane bits alias; they are intentionally unused
    generate
        if (ADDR_W < 32) begin : g_alias_hi
            logic w_unused_hi;
            assign w_unused_hi = ^AB[31:ADDR_W];
        end
    endgenerate
    logic w_unused_lo;
    assign w_unused_lo = ^AB[1:0];

    // Critical-word-first: the offset wraps inside the line, the base is fixed
    assign w_idx    = (widx_q & ~c_line_mask) |
                      ((widx_q + c_widx_w'(beat_q)) & c_line_mask);
    assign w_last   = (beat_q == c_last_beat);
    assign w_accept = (state_q == S_WBURST) && db_ready_q && db_valid;
    assign w_rdata  = mem[w_idx];

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        beat_d     = beat_q;
        widx_d     = widx_q;
        we_d       = we_q;
        md_d       = md_q;
        busy_d     = busy_q;
        md_valid_d = 1'b0;
        md_last_d  = 1'b0;
        db_ready_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    widx_d = AB[ADDR_W-1:2];
                    we_d   = we;
                    busy_d = 1'b1;
                    beat_d = 5'd0;
                    wait_d = 4'(LAT);
                    if (LAT == 0) begin
                        state_d    = we ? S_WBURST : S_RBURST;
                        db_ready_d = we;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_q <= 4'd1) begin
                    state_d    = we_q ? S_WBURST : S_RBURST;
                    db_ready_d = we_q;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_RBURST: begin
                md_d       = w_rdata;
                md_valid_d = 1'b1;
                beat_d     = beat_q + 5'd1;
                if (w_last) begin
                    md_last_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_WBURST: begin
                db_ready_d = 1'b1;
                if (w_accept) begin
                    beat_d = beat_q + 5'd1;
                    if (w_last) begin
                        db_ready_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            wait_q     <= 4'd0;
            beat_q     <= 5'd0;
            widx_q     <= '0;
            we_q       <= 1'b0;
            md_q       <= 32'd0;
            md_valid_q <= 1'b0;
            md_last_q  <= 1'b0;
            db_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            beat_q     <= beat_d;
            widx_q     <= widx_d;
            we_q       <= we_d;
            md_q       <= md_d;
            md_valid_q <= md_valid_d;
            md_last_q  <= md_last_d;
            db_ready_q <= db_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Storage write; contents survive clear, an aborting clear blocks the beat
    always_ff @(posedge clk) begin
        if (w_accept && !clr) begin
            mem[w_idx] <= DB;
        end
    end

    assign MD       = md_q;
    assign md_valid = md_valid_q;
    assign md_last  = md_last_q;
    assign db_ready = db_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_burst_line_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_burst_line_ram
// Purpose  : Directed self-checking bench for burst_line_ram (default params)
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_line_ram;

    logic        clk = 1'b0;
    logic        clr;
    logic        req;
    logic        we;
    logic [31:0] AB;
    logic [31:0] DB;
    logic        db_valid;
    logic        db_ready;
    logic [31:0] MD;
    logic        md_valid;
    logic        md_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // Status vector order: {md_valid, md_last, db_ready, busy, done}
    logic [4:0] st;
    assign st = {md_valid, md_last, db_ready, busy, done};

    burst_line_ram #(.ADDR_W(20), .LINE_WORDS(4), .LAT(2)) dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .we       (we),
        .AB       (AB),
        .DB       (DB),
        .db_valid (db_valid),
        .db_ready (db_ready),
        .MD       (MD),
        .md_valid (md_valid),
        .md_last  (md_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req      = 1'($urandom_range(1));
            we       = 1'($urandom_range(1));
            db_valid = 1'($urandom_range(1));
            AB       = $urandom;
            DB       = $urandom;
            tick();
        end
        n_checks++;
        if (st !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_status: got %b expected %b", st, 5'b00000);
        end
        n_checks++;
        if (MD !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_md: got %h expected %h", MD, 32'd0);
        end
        clr = 1'b0; req = 1'b0; we = 1'b0; db_valid = 1'b0;
        tick();
        n_checks++;
        if (st !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected %b", st, 5'b00000);
        end
    endtask

    task automatic write_line(input logic [31:0] addr,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] d [4];
        logic [4:0]  exp;
        d = '{d0, d1, d2, d3};
        req = 1'b1; we = 1'b1; AB = addr; db_valid = 1'b1; DB = d[0];
        tick();
        req = 1'b0;
        for (int e = 0; e < 3; e++) begin
            exp = (e == 2) ? 5'b00110 : 5'b00010;
            n_checks++;
            if (st !== exp) begin
                n_fail++;
                $display("FAIL wr_wait_e%0d: got %b expected %b", e, st, exp);
            end
            if (e < 2) tick();
        end
        for (int k = 0; k < 4; k++) begin
            DB = d[k];
            tick();
            exp = (k < 3) ? 5'b00110 : 5'b00011;
            n_checks++;
            if (st !== exp) begin
                n_fail++;
                $display("FAIL wr_beat%0d: got %b expected %b", k, st, exp);
            end
        end
        db_valid = 1'b0;
        tick();
        n_checks++;
        if (st !== 5'b00000) begin
            n_fail++;
            $display("FAIL wr_end: got %b expected %b", st, 5'b00000);
        end
    endtask

    task automatic read_line(input logic [31:0] addr,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        logic [4:0]  exp;
        e = '{e0, e1, e2, e3};
        req = 1'b1; we = 1'b0; AB = addr;
        tick();
        req = 1'b0;
        for (int w = 0; w < 3; w++) begin
            n_checks++;
            if (st !== 5'b00010) begin
                n_fail++;
                $display("FAIL rd_wait%0d: got %b expected %b", w, st, 5'b00010);
            end
            if (w < 2) tick();
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            exp = (k < 3) ? 5'b10010 : 5'b11011;
            n_checks++;
            if (st !== exp) begin
                n_fail++;
                $display("FAIL rd_status%0d @%h: got %b expected %b", k, addr, st, exp);
            end
            n_checks++;
            if (MD !== e[k]) begin
                n_fail++;
                $display("FAIL rd_data%0d @%h: got %h expected %h", k, addr, MD, e[k]);
            end
        end
        tick();
        n_checks++;
        if (st !== 5'b00000) begin
            n_fail++;
            $display("FAIL rd_end: got %b expected %b", st, 5'b00000);
        end
    endtask

    task automatic test_line_write();
        write_line(32'h40, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    endtask

    task automatic test_cwf_read();
        read_line(32'h48, 32'h33333333, 32'h44444444, 32'h11111111, 32'h22222222);
    endtask

    task automatic test_reset_keeps_memory();
        test_reset();
        read_line(32'h40, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    endtask

    // Write at AB=0x4C: beats land on words 0x13,0x10,0x11,0x12
    task automatic test_stalled_write();
        int          pat [7];
        logic [31:0] d [4];
        int          acc;
        logic [4:0]  exp;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        d   = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
        acc = 0;
        req = 1'b1; we = 1'b1; AB = 32'h4C; db_valid = 1'b0; DB = 32'hDEADBEEF;
        tick();
        req = 1'b0;
        tick();
        tick();
        for (int j = 0; j < 7; j++) begin
            db_valid = (pat[j] != 0);
            DB       = (pat[j] != 0) ? d[acc] : 32'hDEADBEEF;
            tick();
            acc += pat[j];
            exp = (acc < 4) ? 5'b00110 : 5'b00011;
            n_checks++;
            if (st !== exp) begin
                n_fail++;
                $display("FAIL stall_step%0d: got %b expected %b", j, st, exp);
            end
        end
        db_valid = 1'b0;
        tick();
        n_checks++;
        if (st !== 5'b00000) begin
            n_fail++;
            $display("FAIL stall_end: got %b expected %b", st, 5'b00000);
        end
        read_line(32'h40, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0000);
    endtask

    task automatic test_req_during_busy();
        logic [31:0] e [4];
        logic [4:0]  exp;
        e = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0000};
        req = 1'b1; we = 1'b0; AB = 32'h40;
        tick();
        req = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            req = (k == 1);
            we  = (k == 1);
            AB  = (k == 1) ? 32'h80 : 32'h40;
            tick();
            exp = (k < 3) ? 5'b10010 : 5'b11011;
            n_checks++;
            if (st !== exp || MD !== e[k]) begin
                n_fail++;
                $display("FAIL busy_beat%0d: got %b/%h expected %b/%h", k, st, MD, exp, e[k]);
            end
        end
        req = 1'b0; we = 1'b0;
        tick();
        n_checks++;
        if (st !== 5'b00000) begin
            n_fail++;
            $display("FAIL busy_ignored: got %b expected %b", st, 5'b00000);
        end
        // Accepted on the very first edge with busy low
        read_line(32'h48, 32'hCAFE0003, 32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002);
    endtask

    task automatic test_clr_mid_read();
        write_line(32'hFFFF0, 32'h5EED0000, 32'h5EED0001, 32'h5EED0002, 32'h5EED0003);
        req = 1'b1; we = 1'b0; AB = 32'h40;
        tick();
        req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (st !== 5'b10010 || MD !== 32'hCAFE0002) begin
            n_fail++;
            $display("FAIL clr_pre_beat: got %b/%h expected %b/%h", st, MD, 5'b10010, 32'hCAFE0002);
        end
        clr = 1'b1;
        tick();
        n_checks++;
        if (st !== 5'b00000 || MD !== 32'd0) begin
            n_fail++;
            $display("FAIL clr_abort: got %b/%h expected %b/%h", st, MD, 5'b00000, 32'd0);
        end
        clr = 1'b0;
        tick();
        n_checks++;
        if (st !== 5'b00000) begin
            n_fail++;
            $display("FAIL clr_idle: got %b expected %b", st, 5'b00000);
        end
        read_line(32'hFFFFC, 32'h5EED0003, 32'h5EED0000, 32'h5EED0001, 32'h5EED0002);
        // Upper address bits and byte lane alias onto word 0x12
        read_line(32'h12300049, 32'hCAFE0003, 32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002);
    endtask

    initial begin
        clr = 1'b1; req = 1'b0; we = 1'b0; AB = '0; DB = '0; db_valid = 1'b0;
        test_reset();
        test_line_write();
        test_cwf_read();
        test_reset_keeps_memory();
        test_stalled_write();
        test_req_during_busy();
        test_clr_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/burst_line_ram.md
Name: burst_line_ram

Overview:
- Parametrised, fully synchronous line-burst main memory behind the cache.
- Serves whole cache-line reads and writes as multi-beat 32-bit bursts.
- Adds a configurable access latency, critical-word-first wrapping order, and a write-beat handshake.
- Replaces the fixed 4-word, read-only-burst memory model; storage is word-organised, big-endian within each word.

Parameters:
- ADDR_W, 20, byte-address bits decoded; memory size is 2^ADDR_W bytes, i.e. 2^(ADDR_W-2) words.
- LINE_WORDS, 4, words per line; power of 2, 1 to 16.
- LAT, 2, wait cycles between request acceptance and the first data beat; 0 to 15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- clr  in  1  reset; one clock, synchronous and active-high.
- req  in  1  start a line transfer; sampled only while busy=0.
- we  in  1  with req: 1 = line write, 0 = line read.
- AB  in  32  byte address of the critical word.
- DB  in  32  write beat data.
- db_valid  in  1  write beat present on DB.
- db_ready  out  1  block accepts a write beat this cycle.
- MD  out  32  read beat data, registered.
- md_valid  out  1  MD holds a valid read beat.
- md_last  out  1  final beat of a read burst.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at completion of a read or write.

Behaviour:
- Reset (clr=1 at an edge): state IDLE; counters 0; MD=0; md_valid, md_last, db_ready, busy and done all 0.
  - Memory contents are NOT cleared.
  - Reset mid-burst aborts the burst; words already written stay written.
- Address decode:
  - Word index = AB[ADDR_W-1:2]; AB[1:0] and AB[31:ADDR_W] are ignored (aliasing).
  - Line base = word index with its low log2(LINE_WORDS) bits cleared.
  - Start offset = those low bits.
  - Beat k accesses line base + ((offset + k) mod LINE_WORDS): critical-word-first wrap, never crosses the line.
- Byte order: DB[31:24] / MD[31:24] map to the lowest byte address of the word.
- States: IDLE -> WAIT -> RBURST or WBURST -> IDLE.
- IDLE:
  - On an edge with req=1: latch AB and we, set busy=1, load the wait counter with LAT, go to WAIT.
  - If LAT=0, skip WAIT and go straight to the burst state.
- WAIT: count down LAT edges, then enter RBURST (we=0) or WBURST (we=1).
- Read timing, request accepted at edge 0:
  - MD/md_valid are registered at edges LAT+1 through LAT+LINE_WORDS, one beat per cycle, no gaps and no backpressure.
  - md_last and done are high together with the final beat.
  - busy falls after edge LAT+LINE_WORDS+1.
- Write timing, request accepted at edge 0:
  - db_ready is high after edge LAT.
  - A beat is accepted at any edge where db_ready=1 and db_valid=1; the word is written at that edge.
  - db_valid=0 stalls the beat counter with no timeout.
  - After the LINE_WORDS-th accept: db_ready drops and done pulses high for the following cycle.
  - busy falls one cycle after done.
- req while busy=1 is ignored and is not queued. A request can be accepted at the first edge where busy=0.
- md_valid and db_ready are never high together; done is never high for two consecutive cycles.
- LINE_WORDS=1: single-beat transfer; md_last=md_valid.

Test Plan:
- Reset: hold clr=1 two cycles with random inputs -> MD=0 and all status outputs 0 on the following cycle; a later read returns the data written before reset.
- Line write, LAT=2: req, we=1, AB=0x40, DB=0x11111111/0x22222222/0x33333333/0x44444444 with db_valid always 1 -> db_ready high after edge 2, four accepts at edges 3-6, done after edge 6, busy low after edge 7.
- Critical-word-first read: req, we=0, AB=0x48 -> MD = 0x33333333, 0x44444444, 0x11111111, 0x22222222 after edges 3-6; md_last and done on the last beat.
- Stalled write: db_valid pattern 1,0,0,1,1,0,1 -> exactly four words written in valid order, db_ready held across gaps; readback at AB=0x40 matches.
- Request during busy: pulse req mid-read -> ignored, no extra beats; req asserted when busy=0 is accepted.
- clr mid-read (after second beat) -> all outputs 0 after that edge, state IDLE; next read at AB=0xFFFFC (top line, ADDR_W=20) wraps within its line correctly.
